// File: rtl/tri_feed_if.sv
// Host word-stream bus into tri_feed: 32-bit words with valid/ready and an
// end-of-frame marker on the last word of a record.
interface tri_feed_if;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_last;
    logic        wr_ready;

    modport master (output wr_valid, output wr_data, output wr_last, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, input  wr_last, output wr_ready);
endinterface

// File: rtl/tri_feed.sv
// Assembles 15-word triangle records from the host stream and offers them to
// the transform stage. TRI_FEED_STATS_EN adds the accepted-triangle counter.
//
// state   | meaning
// S_IDLE  | no offer; load head record when one is buffered
// S_OFFER | record offered, stall_in not yet seen high
// S_SEEN  | stall_in seen high; next low sample accepts the record
module tri_feed #(
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    tri_feed_if.slave        wr,
    output logic [14:0][31:0] v_out,
    output logic [23:0]      color_out1,
    output logic [23:0]      color_out2,
    output logic [23:0]      color_out3,
    output logic             out_data_valid,
    output logic             done_out,
    input  logic             stall_in
`ifdef TRI_FEED_STATS_EN
    ,
    output logic [CNT_W-1:0] tri_count
`endif
);

    if (BUF_DEPTH < 1 || BUF_DEPTH > 2 || CNT_W < 1) begin : g_param_check
        $error("tri_feed: BUF_DEPTH must be 1 or 2 and CNT_W at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_OFFER, S_SEEN} state_t;

    localparam logic [1:0] DEPTH_L = 2'(BUF_DEPTH);

    state_t           state_q;
    logic [14:0][31:0] rec_q [2];
    logic [1:0]       done_q;
    logic [3:0]       widx_q;
    logic             wptr_q;
    logic             rptr_q;
    logic [1:0]       occ_q;
    logic [1:0]       occ_next;
    logic             take_word;
    logic             complete;
    logic             release_rec;

    assign take_word   = wr.wr_valid && wr.wr_ready;
    assign complete    = take_word && (widx_q == 4'd14);
    assign release_rec = (state_q == S_SEEN) && !stall_in;

    always_comb begin
        occ_next = occ_q;
        if (complete && !release_rec)
            occ_next = occ_q + 2'd1;
        else if (release_rec && !complete)
            occ_next = occ_q - 2'd1;
    end

    // Record storage carries no reset: a slot is only read after all 15 words are written.
    always_ff @(posedge clock) begin
        if (take_word)
            rec_q[wptr_q][widx_q] <= wr.wr_data;
        if (complete)
            done_q[wptr_q] <= wr.wr_last;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            widx_q         <= '0;
            wptr_q         <= 1'b0;
            rptr_q         <= 1'b0;
            occ_q          <= '0;
            wr.wr_ready    <= 1'b0;
            v_out          <= '0;
            color_out1     <= '0;
            color_out2     <= '0;
            color_out3     <= '0;
            out_data_valid <= 1'b0;
            done_out       <= 1'b0;
`ifdef TRI_FEED_STATS_EN
            tri_count      <= '0;
`endif
        end else begin
            occ_q       <= occ_next;
            wr.wr_ready <= (occ_next < DEPTH_L);

            if (take_word) begin
                widx_q <= complete ? 4'd0 : widx_q + 4'd1;
                if (complete && BUF_DEPTH == 2)
                    wptr_q <= ~wptr_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (occ_q != 2'd0) begin
                        v_out          <= rec_q[rptr_q];
                        color_out1     <= rec_q[rptr_q][3][23:0];
                        color_out2     <= rec_q[rptr_q][7][23:0];
                        color_out3     <= rec_q[rptr_q][11][23:0];
                        done_out       <= done_q[rptr_q];
                        out_data_valid <= 1'b1;
                        state_q        <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (stall_in)
                        state_q <= S_SEEN;
                end
                S_SEEN: begin
                    if (!stall_in) begin
                        out_data_valid <= 1'b0;
                        if (BUF_DEPTH == 2)
                            rptr_q <= ~rptr_q;
                        state_q <= S_IDLE;
`ifdef TRI_FEED_STATS_EN
                        tri_count <= done_out ? '0 : tri_count + 1'b1;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_feed.sv
// Directed bench for tri_feed: single record, back-to-back delivery,
// back-pressure, stall-high offer start and asynchronous reset mid-load/offer.
module tb_tri_feed;

    logic              clock;
    logic              reset;
    logic              stall_in;
    logic [14:0][31:0] v_out;
    logic [23:0]       color_out1;
    logic [23:0]       color_out2;
    logic [23:0]       color_out3;
    logic              out_data_valid;
    logic              done_out;
`ifdef TRI_FEED_STATS_EN
    logic [15:0]       tri_count;
`endif

    tri_feed_if bus ();

    tri_feed #(.BUF_DEPTH(2), .CNT_W(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .wr             (bus.slave),
        .v_out          (v_out),
        .color_out1     (color_out1),
        .color_out2     (color_out2),
        .color_out3     (color_out3),
        .out_data_valid (out_data_valid),
        .done_out       (done_out),
        .stall_in       (stall_in)
`ifdef TRI_FEED_STATS_EN
        ,
        .tri_count      (tri_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks   = 0;
    int          failures = 0;
    bit          auto_ack = 0;
    int          ack_phase = 0;
    int          received = 0;
    bit          cur_last = 0;
    int          exp_seed [$];
    bit          exp_last [$];
    logic [15:0] exp_cnt  = '0;
    logic [14:0][31:0] held;

    function automatic logic [31:0] word_of(input int seed, input int k);
        return (32'(seed) << 24) | (32'(k + 1) << 16) | 32'(seed);
    endfunction

    function automatic logic [14:0][31:0] rec_of(input int seed);
        logic [14:0][31:0] r;
        for (int k = 0; k < 15; k++) r[k] = word_of(seed, k);
        return r;
    endfunction

    task automatic check(input string tag, input logic [479:0] obs, input logic [479:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $display("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic note_accept(input bit last);
        exp_cnt = last ? 16'd0 : exp_cnt + 16'd1;
`ifdef TRI_FEED_STATS_EN
        check("tri_count", tri_count, exp_cnt);
`endif
    endtask

    task automatic consumer();
        case (ack_phase)
            0: if (out_data_valid) begin
                if (exp_seed.size() == 0) begin
                    timeout_fail("b2b_unexpected_record");
                end else begin
                    automatic int s = exp_seed.pop_front();
                    cur_last = exp_last.pop_front();
                    check("b2b_data", v_out, rec_of(s));
                    check("b2b_color2", color_out2, word_of(s, 7) & 32'h00FF_FFFF);
                    check("b2b_done", done_out, cur_last);
                end
                stall_in  = 1'b1;
                ack_phase = 1;
            end
            1: begin
                check("b2b_hold_valid", out_data_valid, 1'b1);
                stall_in  = 1'b0;
                ack_phase = 2;
            end
            default: begin
                check("b2b_gap_low", out_data_valid, 1'b0);
                received++;
                note_accept(cur_last);
                ack_phase = 0;
            end
        endcase
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (auto_ack) consumer();
    endtask

    task automatic send_rec(input int seed, input bit last, input int nwords);
        for (int k = 0; k < nwords; k++) begin
            automatic int budget = 0;
            bus.wr_valid = 1'b1;
            bus.wr_data  = word_of(seed, k);
            bus.wr_last  = (k == 14) ? last : 1'b0;
            while (!bus.wr_ready && budget < 200) begin
                step();
                budget++;
            end
            if (budget >= 200) timeout_fail("send_wr_ready");
            step();
        end
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        stall_in     = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_last  = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_valid", out_data_valid, 1'b0);
        check("rst_wr_ready", bus.wr_ready, 1'b0);
        check("rst_v_out", v_out, '0);
        check("rst_done", done_out, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        step();
        check("wr_ready_after_rst", bus.wr_ready, 1'b1);

        // Single triangle, minimum latency, stall-then-release acceptance
        send_rec(0, 1'b1, 15);
        check("lat_edge_e", out_data_valid, 1'b0);
        step();
        check("lat_edge_e1", out_data_valid, 1'b1);
        check("single_v_out", v_out, rec_of(0));
        check("single_v_out0", v_out[0], 32'h0001_0000);
        check("single_color1", color_out1, 24'h04_0000);
        check("single_color2", color_out2, 24'h08_0000);
        check("single_color3", color_out3, 24'h0C_0000);
        check("single_done", done_out, 1'b1);
        stall_in = 1'b1;
        step();
        check("single_valid_stalled", out_data_valid, 1'b1);
        stall_in = 1'b0;
        step();
        check("single_valid_clear", out_data_valid, 1'b0);
        note_accept(1'b1);

        // Back-to-back records with an acknowledging consumer
        auto_ack = 1;
        for (int i = 0; i < 4; i++) begin
            exp_seed.push_back(3 + i);
            exp_last.push_back(i == 3);
        end
        for (int i = 0; i < 4; i++) send_rec(3 + i, i == 3, 15);
        begin
            automatic int budget = 0;
            while ((received < 4 || ack_phase != 0) && budget < 400) begin
                step();
                budget++;
            end
            if (budget >= 400) timeout_fail("b2b_delivery");
        end
        auto_ack = 0;
        check("b2b_received", received, 4);
        check("b2b_queue_empty", exp_seed.size(), 0);

        // Back-pressure: consumer never raises stall_in
        stall_in = 1'b0;
        send_rec(1, 1'b0, 15);
        step();
        check("bp_valid1", out_data_valid, 1'b1);
        send_rec(2, 1'b0, 15);
        check("bp_full_ready", bus.wr_ready, 1'b0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = word_of(9, 0);
        for (int i = 0; i < 3; i++) step();
        check("bp_third_blocked", bus.wr_ready, 1'b0);
        check("bp_valid_held", out_data_valid, 1'b1);
        check("bp_data_held", v_out, rec_of(1));
        bus.wr_valid = 1'b0;
        stall_in = 1'b1;
        step();
        stall_in = 1'b0;
        step();
        check("bp_release_valid", out_data_valid, 1'b0);
        check("bp_release_ready", bus.wr_ready, 1'b1);
        note_accept(1'b0);
        step();
        check("bp_second_valid", out_data_valid, 1'b1);
        check("bp_second_data", v_out, rec_of(2));
        stall_in = 1'b1;
        step();
        stall_in = 1'b0;
        step();
        check("bp_second_clear", out_data_valid, 1'b0);
        note_accept(1'b0);

        // stall_in already high when the offer begins
        stall_in = 1'b1;
        send_rec(7, 1'b1, 15);
        step();
        check("sh_valid", out_data_valid, 1'b1);
        held = v_out;
        check("sh_data", held, rec_of(7));
        for (int i = 0; i < 3; i++) step();
        check("sh_no_accept", out_data_valid, 1'b1);
        check("sh_stable", v_out, held);
        stall_in = 1'b0;
        step();
        check("sh_accept", out_data_valid, 1'b0);
        check("sh_data_kept", v_out, rec_of(7));
        note_accept(1'b1);

        // Asynchronous reset during an offer and a partial load
        send_rec(8, 1'b0, 15);
        step();
        check("rm_offer_valid", out_data_valid, 1'b1);
        send_rec(9, 1'b0, 7);
        #2 reset = 1'b1;
        #1;
        exp_cnt = '0;
        check("rm_valid", out_data_valid, 1'b0);
        check("rm_v_out", v_out, '0);
        check("rm_color1", color_out1, 24'h0);
        check("rm_done", done_out, 1'b0);
        check("rm_wr_ready", bus.wr_ready, 1'b0);
`ifdef TRI_FEED_STATS_EN
        check("rm_tri_count", tri_count, exp_cnt);
`endif
        step();
        reset = 1'b0;
        step();
        check("rm_ready_back", bus.wr_ready, 1'b1);
        send_rec(10, 1'b1, 15);
        step();
        check("rm_clean_valid", out_data_valid, 1'b1);
        check("rm_clean_data", v_out, rec_of(10));
        check("rm_clean_done", done_out, 1'b1);
        stall_in = 1'b1;
        step();
        stall_in = 1'b0;
        step();
        check("rm_clean_accept", out_data_valid, 1'b0);
        note_accept(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
